// File: rtl/alu_execute_stage_if.sv
// Operation and result bus for the ALU execute stage.
// The master side presents operations and consumes results; the slave side
// is the execute stage itself.
interface alu_execute_stage_if #(
  parameter int WIDTH = 32
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Negative;
  logic             Carry;
  logic             Overflow;
  logic             illegal_op;

  modport master (
    output flush, in_valid, ALUControl, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, Negative, Carry, Overflow,
           illegal_op
  );

  modport slave (
    input  flush, in_valid, ALUControl, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero, Negative, Carry, Overflow,
           illegal_op
  );
endinterface

// File: rtl/alu_execute_stage.sv
// ALU execute stage: computes result and NZCV flags for each accepted op and
// holds them in a 2-entry in-order buffer so downstream can stall.
//
//   state | meaning
//   ------+-----------------------------------------------
//   EMPTY | no buffered result, out_valid low
//   ONE   | head holds one result
//   FULL  | head and tail both hold results, in_ready low
module alu_execute_stage #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  alu_execute_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             illegal;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           head_q, tail_q, head_d, op_entry;
  logic             head_load, head_from_tail, tail_load;
  logic             push, pop;
  logic             is_sub, add_ovf;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // Subtract and slt share the adder with B inverted and a carry-in of one.
  always_comb begin
    is_sub  = (bus.ALUControl == 3'b001) || (bus.ALUControl == 3'b101);
    b_eff   = is_sub ? ~bus.SrcB : bus.SrcB;
    sum     = {1'b0, bus.SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    add_ovf = (bus.SrcA[WIDTH-1] == b_eff[WIDTH-1]) &&
              (sum[WIDTH-1] != bus.SrcA[WIDTH-1]);
    op_entry = '0;
    case (bus.ALUControl)
      3'b000, 3'b001: begin
        op_entry.result   = sum[WIDTH-1:0];
        op_entry.carry    = sum[WIDTH];
        op_entry.overflow = add_ovf;
      end
      3'b010: op_entry.result = bus.SrcA & bus.SrcB;
      3'b011: op_entry.result = bus.SrcA | bus.SrcB;
      // Signed less-than is N xor V of A-B, so it never depends on wrap.
      3'b101: op_entry.result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: op_entry.illegal = 1'b1;
    endcase
    op_entry.zero     = (op_entry.result == '0);
    op_entry.negative = op_entry.result[WIDTH-1];
  end

  assign bus.in_ready  = ~rst & ~bus.flush & (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next occupancy and which buffer slot loads; flush beats push and pop.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            head_load = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_load = 1'b1;
          end else if (push) begin
            state_d   = FULL;
            tail_load = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            head_load      = 1'b1;
            head_from_tail = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign head_d = head_from_tail ? tail_q : op_entry;

  // Buffer storage; head drives the outputs directly so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (head_load) head_q <= head_d;
      if (tail_load) tail_q <= op_entry;
    end
  end

  assign bus.ALUResult  = head_q.result;
  assign bus.Zero       = head_q.zero;
  assign bus.Negative   = head_q.negative;
  assign bus.Carry      = head_q.carry;
  assign bus.Overflow   = head_q.overflow;
  assign bus.illegal_op = head_q.illegal;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Bench for alu_execute_stage: directed vectors plus randomized traffic
// checked against a queue-based reference model.
module tb_alu_execute_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_execute_stage_if #(.WIDTH(32)) bus ();
  alu_execute_stage #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;  // {Zero, Negative, Carry, Overflow, illegal_op}
  } exp_t;

  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   pops     = 0;
  int   max_q    = 0;
  bit   mon_en   = 1'b0;
  bit   prev_rst = 1'b1;
  exp_t q[$];

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_op(input logic [2:0] ctl,
                                    input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    longint unsigned ua, ub, s;
    longint          sa, sb, sv;
    logic            c, v, ill;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; ill = 1'b0;
    e.r = '0;
    case (ctl)
      3'd0: begin
        s = ua + ub; e.r = s[31:0]; c = s[32];
        sv = sa + sb; v = (sv > MAX_S) || (sv < MIN_S);
      end
      3'd1: begin
        e.r = a - b; c = (ua >= ub);
        sv = sa - sb; v = (sv > MAX_S) || (sv < MIN_S);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd5: e.r = (sa < sb) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
    e.f = {(e.r == 32'd0), e.r[31], c, v, ill};
    return e;
  endfunction

  // Reference model: compare DUT against queue head, then apply this cycle's
  // handshakes to the queue.
  bit   exp_rdy, m_push, m_pop;
  exp_t h;
  always @(negedge clk) begin
    if (mon_en) begin
      exp_rdy = !rst && !bus.flush && (q.size() < 2);
      check_val("in_ready", bus.in_ready, exp_rdy);
      check_val("out_valid", bus.out_valid, q.size() != 0);
      if (prev_rst) begin
        check_val("rst_result", bus.ALUResult, 0);
        check_val("rst_flags", {bus.Zero, bus.Negative, bus.Carry,
                                bus.Overflow, bus.illegal_op}, 0);
      end else if (q.size() != 0) begin
        h = q[0];
        check_val("result", bus.ALUResult, h.r);
        check_val("flags", {bus.Zero, bus.Negative, bus.Carry,
                            bus.Overflow, bus.illegal_op}, h.f);
      end
      m_push = bus.in_valid && exp_rdy;
      m_pop  = (q.size() != 0) && bus.out_ready;
      if (rst || bus.flush) begin
        q.delete();
      end else begin
        if (m_pop) begin
          void'(q.pop_front());
          pops++;
        end
        if (m_push) q.push_back(model_op(bus.ALUControl, bus.SrcA, bus.SrcB));
      end
      if (q.size() > max_q) max_q = q.size();
      prev_rst = rst;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] ctl, input logic [31:0] a,
                        input logic [31:0] b);
    bus.ALUControl = ctl;
    bus.SrcA       = a;
    bus.SrcB       = b;
  endtask

  task automatic rand_op();
    logic [31:0] a, b;
    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    set_op(3'($urandom_range(0, 7)), a, b);
  endtask

  task automatic directed(input string tag, input logic [2:0] ctl,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [4:0] ef);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    set_op(ctl, a, b);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_val({tag, "_res"}, bus.ALUResult, er);
    check_val({tag, "_flags"}, {bus.Zero, bus.Negative, bus.Carry,
                                bus.Overflow, bus.illegal_op}, ef);
    step();
  endtask

  initial begin
    bit acc;
    int p0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    set_op(3'd0, 32'd1, 32'd2);
    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_val("release_ready", bus.in_ready, 1);
    check_val("release_valid", bus.out_valid, 0);
    step();

    directed("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'b10100);
    directed("sub_ovf", 3'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 5'b00110);
    directed("slt_neg", 3'd5, 32'hFFFF_FFFB, 32'd3, 32'd1, 5'b00000);
    directed("slt_pos", 3'd5, 32'd3, 32'hFFFF_FFFB, 32'd0, 5'b10000);
    directed("and", 3'd2, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 5'b00000);
    directed("or", 3'd3, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 5'b00000);
    directed("illegal", 3'd6, 32'd7, 32'd9, 32'd0, 5'b10001);
    directed("after_ill", 3'd0, 32'd2, 32'd3, 32'd5, 5'b00000);

    // Backpressure: two accepted, third refused until FULL drains to ONE.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_op(3'd0, 32'd10, 32'd1);
    step();
    set_op(3'd1, 32'd20, 32'd2);
    step();
    set_op(3'd3, 32'd30, 32'd3);
    @(negedge clk);
    check_val("bp_full_ready", bus.in_ready, 0);
    step();
    bus.out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    check_val("bp_accept", acc, 1);
    for (int k = 0; k < 10 && q.size() != 0; k++) step();
    check_val("bp_drained", q.size(), 0);

    // Streaming at full rate.
    p0 = pops;
    max_q = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_op();
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    check_val("stream_pops", pops - p0, 100);
    check_val("stream_maxq", max_q, 1);

    // Flush of a full buffer with an op presented in the same cycle.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    rand_op();
    step();
    rand_op();
    step();
    bus.flush = 1'b1;
    set_op(3'd0, 32'h1234_5678, 32'd1);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_val("flush_valid", bus.out_valid, 0);
    step();
    bus.out_ready = 1'b1;
    repeat (5) step();

    // Random traffic including flush and mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 24) == 0);
      rst           = ($urandom_range(0, 59) == 0);
      rand_op();
      step();
    end
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    check_val("final_empty", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
